latch_reader: RTL and testbench

Clocked reader for the two-rail output of the gate-level D latch. Samples the asynchronous Q/Qbar pair into the Clock domain and waits for a settled complementary value. Reports rising and falling edges, flags a stuck or illegal rail pair, and returns the settled bit to a requester over a Read/Ack handshake. Sits between the latch (or any dual-rail storage element) and the synchronous lab datapath.

---
 rtl/latch_reader_pkg.sv | 17 +
 rtl/latch_reader_sync_chain.sv | 26 ++
 rtl/latch_reader.sv | 149 ++++++++++++++
 tb/tb_latch_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_reader_pkg.sv
// Shared types and defaults for the dual-rail latch reader.
package latch_reader_pkg;

  typedef enum logic [1:0] {
    StSettle,
    StValid,
    StFault
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 8;

  // Reset image of the {Q, Qbar} pair: a legal stored 0.
  localparam logic [1:0] RAIL_RESET = 2'b01;

endpackage

// File: rtl/latch_reader_sync_chain.sv
// Two-bit synchronizer chain for the asynchronous {Q, Qbar} rail pair.
module sync_chain
  import latch_reader_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] stage_q [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RAIL_RESET;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/latch_reader.sv
// Clocked reader for a dual-rail latch: settle filter, edge/fault reporting, Read/Ack port.
// Define LATCH_READER_EDGE_COUNT_EN to build the EdgeCount counter; otherwise it reads 0.
module latch_reader
  import latch_reader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Q,
  input  logic             Qbar,
  input  logic             Read,
  output logic             Ack,
  output logic             Value,
  output logic             Valid,
  output logic             Rise,
  output logic             Fall,
  output logic             Fault,
  output logic [CNT_W-1:0] EdgeCount
);

  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_CYCLES);

  logic [1:0]     sync_pair, prev_q;
  state_e         state_q, state_d;
  logic [SCW-1:0] good_q, good_d, bad_q, bad_d;
  logic [SCW-1:0] base_good, base_bad, good_n, bad_n;
  logic           value_q, value_d, have_q, have_d;
  logic           rise_q, rise_d, fall_q, fall_d;
  logic           ack_q, ack_d, armed_q, armed_d;
  logic           sq, sqb, comp, same, hold;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(Clock),
    .reset(Reset),
    .din  ({Q, Qbar}),
    .dout (sync_pair)
  );

  assign sq   = sync_pair[1];
  assign sqb  = sync_pair[0];
  assign comp = sq ^ sqb;
  assign same = (sync_pair == prev_q);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    value_d = value_q;
    have_d  = have_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    // Leaving VALID or FAULT counts the triggering sample from cleared counters.
    base_good = (state_q == StSettle) ? good_q : '0;
    base_bad  = (state_q == StSettle) ? bad_q  : '0;
    if (comp) begin
      good_n = same ? base_good + SCW'(1) : SCW'(1);
      bad_n  = '0;
    end else begin
      good_n = '0;
      bad_n  = base_bad + SCW'(1);
    end

    hold = ((state_q == StValid) && (sync_pair == {value_q, ~value_q})) ||
           ((state_q == StFault) && !comp);

    if (!hold) begin
      if (good_n == SETTLE_MAX) begin
        state_d = StValid;
        good_d  = '0;
        bad_d   = '0;
        value_d = sq;
        have_d  = 1'b1;
        if (have_q && (sq != value_q)) begin
          rise_d = sq;
          fall_d = ~sq;
        end
      end else if (bad_n == SETTLE_MAX) begin
        state_d = StFault;
        good_d  = '0;
        bad_d   = '0;
      end else begin
        state_d = StSettle;
        good_d  = good_n;
        bad_d   = bad_n;
      end
    end

    // Only acknowledge when VALID persists, so Value is good in the Ack cycle.
    ack_d   = Read && armed_q && (state_q == StValid) && (state_d == StValid);
    armed_d = !Read ? 1'b1 : (ack_d ? 1'b0 : armed_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_q  <= RAIL_RESET;
      state_q <= StSettle;
      good_q  <= '0;
      bad_q   <= '0;
      value_q <= 1'b0;
      have_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sync_pair;
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      value_q <= value_d;
      have_q  <= have_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

`ifdef LATCH_READER_EDGE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (rise_d || fall_d) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign EdgeCount = count_q;
`else
  assign EdgeCount = '0;
`endif

  assign Ack   = ack_q;
  assign Value = value_q;
  assign Valid = (state_q == StValid);
  assign Fault = (state_q == StFault);
  assign Rise  = rise_q;
  assign Fall  = fall_q;

endmodule

// File: tb/tb_latch_reader.sv
// Directed bench for latch_reader: per-cycle vector table plus handshake/reset sequences.
module tb_latch_reader;

  logic       Clock = 1'b0;
  logic       Reset, Q, Qbar, Read;
  logic       Ack, Value, Valid, Rise, Fall, Fault;
  logic [1:0] EdgeCount;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  latch_reader #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(4),
    .CNT_W        (2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Q        (Q),
    .Qbar     (Qbar),
    .Read     (Read),
    .Ack      (Ack),
    .Value    (Value),
    .Valid    (Valid),
    .Rise     (Rise),
    .Fall     (Fall),
    .Fault    (Fault),
    .EdgeCount(EdgeCount)
  );

  typedef struct {
    logic q, qb, v, val, r, f, flt;
    int   c;
  } vec_t;

  vec_t vecs[$];

  function automatic int ecnt(int c);
`ifdef LATCH_READER_EDGE_COUNT_EN
    return c % 4;
`else
    return 0;
`endif
  endfunction

  task automatic add(int n, logic q, logic qb, logic v, logic val, logic r, logic f,
                     logic flt, int c);
    vec_t e;
    e.q = q; e.qb = qb; e.v = v; e.val = val; e.r = r; e.f = f; e.flt = flt; e.c = c;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  task automatic check(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, early;
    Reset = 1'b1; Q = 1'b0; Qbar = 1'b1; Read = 1'b0;

    //  n  q  qb v  val r  f  flt c
    add(3, 0, 1, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 1, 0, 0, 0, 0, 0);
    add(2, 1, 0, 1, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 0, 0, 1);
    add(2, 1, 0, 1, 1, 0, 0, 0, 1);
    add(2, 0, 1, 1, 1, 0, 0, 0, 1);
    add(3, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 1, 0, 2);
    add(2, 0, 1, 1, 0, 0, 0, 0, 2);
    add(2, 0, 0, 1, 0, 0, 0, 0, 2);   // glitch to 0/0
    add(5, 0, 1, 0, 0, 0, 0, 0, 2);
    add(3, 0, 1, 1, 0, 0, 0, 0, 2);
    add(2, 1, 1, 1, 0, 0, 0, 0, 2);   // illegal pair
    add(3, 1, 1, 0, 0, 0, 0, 0, 2);
    add(3, 1, 1, 0, 0, 0, 0, 1, 2);
    add(2, 1, 0, 0, 0, 0, 0, 1, 2);
    add(3, 1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 1, 1, 1, 0, 0, 3);
    add(2, 1, 0, 1, 1, 0, 0, 0, 3);
    add(2, 0, 1, 1, 1, 0, 0, 0, 3);
    add(3, 0, 1, 0, 1, 0, 0, 0, 3);
    add(1, 0, 1, 1, 0, 0, 1, 0, 4);   // count wraps at CNT_W=2
    add(2, 0, 1, 1, 0, 0, 0, 0, 4);

    repeat (3) step();
    check("reset_valid", 0, Valid, 0);
    check("reset_value", 0, Value, 0);
    check("reset_fault", 0, Fault, 0);
    check("reset_ack", 0, Ack, 0);
    check("reset_count", 0, EdgeCount, 0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      Q = vecs[i].q; Qbar = vecs[i].qb;
      step();
      check("valid", i + 1, Valid, vecs[i].v);
      check("value", i + 1, Value, vecs[i].val);
      check("rise", i + 1, Rise, vecs[i].r);
      check("fall", i + 1, Fall, vecs[i].f);
      check("fault", i + 1, Fault, vecs[i].flt);
      check("ack_idle", i + 1, Ack, 0);
      check("count", i + 1, EdgeCount, ecnt(vecs[i].c));
    end

    // Read held through VALID: exactly one Ack, one clock after Read.
    Read = 1'b1;
    step();
    check("ack_first", 0, Ack, 1);
    acks = int'(Ack);
    repeat (9) begin
      step();
      acks += int'(Ack);
    end
    check("ack_once", 0, acks, 1);
    Read = 1'b0;
    step();

    // Read issued during SETTLE waits for VALID.
    Q = 1'b1; Qbar = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (Valid && n < 10);
    check("settle_entry", 0, Valid, 0);
    Read = 1'b1;
    n = 0; early = 0;
    while (!Valid && n < 20) begin
      step();
      n++;
      early |= int'(Ack);
    end
    check("settle_read_wait", 0, n, 3);
    check("early_ack", 0, early, 0);
    check("settle_value", 0, Value, 1);
    check("settle_rise", 0, Rise, 1);
    step();
    check("ack_after_valid", 0, Ack, 1);
    check("ack_value", 0, Value, 1);
    step();
    check("ack_single", 0, Ack, 0);
    Read = 1'b0;
    step();

    // Read in the very cycle VALID is left: no Ack.
    Q = 1'b0; Qbar = 1'b1;
    step();
    step();
    check("pre_exit_valid", 0, Valid, 1);
    Read = 1'b1;
    step();
    check("exit_valid", 0, Valid, 0);
    check("exit_ack", 0, Ack, 0);
    step();
    check("exit_ack_late", 0, Ack, 0);
    Read = 1'b0;
    n = 0;
    while (!Valid && n < 20) begin
      step();
      n++;
    end
    check("resettle", 0, Valid, 1);

    // Reset from FAULT with Read in flight.
    Q = 1'b1; Qbar = 1'b1;
    n = 0;
    while (!Fault && n < 20) begin
      step();
      n++;
    end
    check("fault_reached", 0, Fault, 1);
    check("fault_steps", 0, n, 6);
    Read = 1'b1;
    step();
    check("fault_no_ack", 0, Ack, 0);
    Q = 1'b0; Qbar = 1'b1; Reset = 1'b1;
    step();
    check("mid_reset_fault", 0, Fault, 0);
    check("mid_reset_valid", 0, Valid, 0);
    check("mid_reset_ack", 0, Ack, 0);
    check("mid_reset_count", 0, EdgeCount, 0);
    Reset = 1'b0;
    repeat (3) step();
    check("post_reset_settling", 0, Valid, 0);
    step();
    check("post_reset_valid", 0, Valid, 1);
    acks = 0;
    repeat (3) begin
      step();
      acks += int'(Ack);
    end
    check("stale_read_no_ack", 0, acks, 0);
    Read = 1'b0;
    step();
    Read = 1'b1;
    step();
    check("reissued_ack", 0, Ack, 1);
    Read = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
